// File: rtl/mem_write_sequencer_pkg.sv
// Shared types and helpers for the RAM write-port sequencer.
//   state_e    : sequencer FSM states (clear sweep / idle forwarding)
//   addr_width : address width for a given RAM depth, shared with the RAM model
package mem_write_sequencer_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  // Address width for a RAM of 'depth' words; never narrower than one bit.
  function automatic int unsigned addr_width(input int unsigned depth);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < depth) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage : mem_write_sequencer_pkg

// File: rtl/mem_write_sequencer_if.sv
// Host handshake, status and RAM write-port bundle of the write sequencer.
//   master : sequencer side (drives s_ready, status and RAM write pins)
//   slave  : host / RAM side (drives clear_req and the write request)
// Signals:
//   clear_req          one-cycle clear sweep request
//   s_valid/s_ready    host write handshake, s_addr/s_data payload
//   busy, done, err    sweep in progress, final sweep write, dropped write
//   wea, addra, dia    RAM write enable, address, data
interface mem_write_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned AW         = 4
) ();

  logic                  clear_req;
  logic                  s_valid;
  logic                  s_ready;
  logic [AW-1:0]         s_addr;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic                  wea;
  logic [AW-1:0]         addra;
  logic [DATA_WIDTH-1:0] dia;

  modport master (
    input  clear_req,
    input  s_valid,
    input  s_addr,
    input  s_data,
    output s_ready,
    output busy,
    output done,
    output err,
    output wea,
    output addra,
    output dia
  );

  modport slave (
    output clear_req,
    output s_valid,
    output s_addr,
    output s_data,
    input  s_ready,
    input  busy,
    input  done,
    input  err,
    input  wea,
    input  addra,
    input  dia
  );

endinterface : mem_write_sequencer_if

// File: rtl/mem_write_sequencer.sv
// Write-port driver for a simple dual-port state RAM.
// After reset, and on clear_req, sweeps every address writing CLEAR_VALUE;
// otherwise forwards host writes accepted on the valid/ready handshake.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      mem_write_sequencer_if.master (handshake, status, RAM write pins)
// wea/addra/dia/done/err/busy are registered; s_ready decodes the state register.
module mem_write_sequencer
  import mem_write_sequencer_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH  = 8,
  parameter int unsigned          DEPTH       = 16,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  mem_write_sequencer_if.master  bus
);

  localparam int unsigned AW = addr_width(DEPTH);

  state_e                state_q,  state_d;
  logic [AW-1:0]         cnt_q,    cnt_d;
  logic                  wea_q,    wea_d;
  logic [AW-1:0]         addra_q,  addra_d;
  logic [DATA_WIDTH-1:0] dia_q,    dia_d;
  logic                  done_q,   done_d;
  logic                  err_q,    err_d;
  logic                  busy_q,   busy_d;
  logic                  addr_ok;

  // One extra bit so the comparison also holds when DEPTH is a power of two.
  assign addr_ok = ({1'b0, bus.s_addr} < (AW+1)'(DEPTH));

  // Next-state and registered-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wea_d   = 1'b0;
    addra_d = addra_q;
    dia_d   = dia_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        wea_d   = 1'b1;
        addra_d = cnt_q;
        dia_d   = CLEAR_VALUE;
        if (cnt_q == AW'(DEPTH - 1)) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end

      ST_IDLE: begin
        // s_ready is implied by being in IDLE.
        if (bus.s_valid) begin
          if (addr_ok) begin
            wea_d   = 1'b1;
            addra_d = bus.s_addr;
            dia_d   = bus.s_data;
          end else begin
            err_d = 1'b1;
          end
        end
        // A write accepted alongside clear_req still issues; the sweep follows.
        if (bus.clear_req) begin
          state_d = ST_CLEAR;
        end
      end

      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d == ST_CLEAR) || done_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      wea_q   <= 1'b0;
      addra_q <= '0;
      dia_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wea_q   <= wea_d;
      addra_q <= addra_d;
      dia_q   <= dia_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.s_ready = (state_q == ST_IDLE);
  assign bus.wea     = wea_q;
  assign bus.addra   = addra_q;
  assign bus.dia     = dia_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.busy    = busy_q;

endmodule : mem_write_sequencer

// File: tb/tb_mem_write_sequencer.sv
// Directed bench: two sequencers (DEPTH 16 and DEPTH 12) each driving a
// zero-latency simple dual-port RAM model read back through port B.
module tb_mem_write_sequencer;

  logic clk;
  logic reset_n;
  int   tests_run;
  int   tests_failed;

  mem_write_sequencer_if #(.DATA_WIDTH(8), .AW(4)) bus1 ();
  mem_write_sequencer_if #(.DATA_WIDTH(8), .AW(4)) bus2 ();

  mem_write_sequencer #(.DATA_WIDTH(8), .DEPTH(16), .CLEAR_VALUE(8'hA5)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1.master));

  mem_write_sequencer #(.DATA_WIDTH(8), .DEPTH(12), .CLEAR_VALUE(8'hA5)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2.master));

  // RAM models: port A write, port B asynchronous read.
  logic [7:0] mem1 [16];
  logic [7:0] mem2 [16];
  logic [3:0] addrb1, addrb2;
  logic [7:0] dob1, dob2;

  always @(posedge clk) begin
    if (bus1.wea) mem1[bus1.addra] <= bus1.dia;
    if (bus2.wea) mem2[bus2.addra] <= bus2.dia;
  end
  assign dob1 = mem1[addrb1];
  assign dob2 = mem2[addrb2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checks one sweep cycle on dut1: expected address idx, done/s_ready on last.
  task automatic check_sweep1(input string tag, input int idx);
    logic last;
    last = (idx == 15);
    tests_run++;
    if (bus1.wea !== 1'b1 || bus1.addra !== 4'(idx) || bus1.dia !== 8'hA5) begin
      tests_failed++;
      $display("FAIL %s_write[%0d]: got wea=%b addra=%0d dia=%h, need wea=1 addra=%0d dia=a5",
               tag, idx, bus1.wea, bus1.addra, bus1.dia, idx);
    end
    tests_run++;
    if (bus1.done !== last || bus1.s_ready !== last || bus1.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_status[%0d]: got done=%b s_ready=%b busy=%b, need done=%b s_ready=%b busy=1",
               tag, idx, bus1.done, bus1.s_ready, bus1.busy, last, last);
    end
  endtask

  // Checks the cycle after a sweep finishes on dut1.
  task automatic check_after_sweep1(input string tag);
    tests_run++;
    if (bus1.wea !== 1'b0 || bus1.done !== 1'b0 || bus1.busy !== 1'b0 || bus1.s_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_end: got wea=%b done=%b busy=%b s_ready=%b, need 0 0 0 1",
               tag, bus1.wea, bus1.done, bus1.busy, bus1.s_ready);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus1.wea !== 1'b0 || bus1.addra !== 4'd0 || bus1.dia !== 8'h00 || bus1.done !== 1'b0 ||
        bus1.err !== 1'b0 || bus1.busy !== 1'b1 || bus1.s_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_values: got wea=%b addra=%0d dia=%h done=%b err=%b busy=%b s_ready=%b, need 0 0 00 0 0 1 0",
               bus1.wea, bus1.addra, bus1.dia, bus1.done, bus1.err, bus1.busy, bus1.s_ready);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check_sweep1("reset_sweep", i);
    end
    @(negedge clk);
    check_after_sweep1("reset_sweep");
    for (int i = 0; i < 16; i++) begin
      addrb1 = 4'(i);
      #1;
      tests_run++;
      if (dob1 !== 8'hA5) begin
        tests_failed++;
        $display("FAIL reset_readback[%0d]: got %h, need a5", i, dob1);
      end
    end
    // DEPTH=12 instance: swept words 0..11 must hold the clear value.
    for (int i = 0; i < 12; i++) begin
      addrb2 = 4'(i);
      #1;
      tests_run++;
      if (dob2 !== 8'hA5) begin
        tests_failed++;
        $display("FAIL reset_readback12[%0d]: got %h, need a5", i, dob2);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] a [3];
    logic [7:0] d [3];
    a[0] = 4'd3; d[0] = 8'h11;
    a[1] = 4'd4; d[1] = 8'h22;
    a[2] = 4'd3; d[2] = 8'h33;
    @(negedge clk);
    bus1.s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus1.s_addr = a[i];
      bus1.s_data = d[i];
      @(negedge clk);
      tests_run++;
      if (bus1.wea !== 1'b1 || bus1.addra !== a[i] || bus1.dia !== d[i] || bus1.s_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL b2b_write[%0d]: got wea=%b addra=%0d dia=%h s_ready=%b, need 1 %0d %h 1",
                 i, bus1.wea, bus1.addra, bus1.dia, bus1.s_ready, a[i], d[i]);
      end
    end
    bus1.s_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus1.wea !== 1'b0 || bus1.addra !== 4'd3 || bus1.dia !== 8'h33) begin
      tests_failed++;
      $display("FAIL b2b_idle_hold: got wea=%b addra=%0d dia=%h, need 0 3 33",
               bus1.wea, bus1.addra, bus1.dia);
    end
    addrb1 = 4'd3; #1;
    tests_run++;
    if (dob1 !== 8'h33) begin
      tests_failed++;
      $display("FAIL b2b_readback3: got %h, need 33", dob1);
    end
    addrb1 = 4'd4; #1;
    tests_run++;
    if (dob1 !== 8'h22) begin
      tests_failed++;
      $display("FAIL b2b_readback4: got %h, need 22", dob1);
    end
  endtask

  task automatic test_out_of_range;
    @(negedge clk);
    bus2.s_valid = 1'b1;
    bus2.s_addr  = 4'd13;
    bus2.s_data  = 8'hFF;
    tests_run++;
    if (bus2.s_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL oor_ready: got s_ready=%b, need 1", bus2.s_ready);
    end
    @(negedge clk);
    bus2.s_valid = 1'b0;
    tests_run++;
    if (bus2.err !== 1'b1 || bus2.wea !== 1'b0) begin
      tests_failed++;
      $display("FAIL oor_err: got err=%b wea=%b, need err=1 wea=0", bus2.err, bus2.wea);
    end
    @(negedge clk);
    tests_run++;
    if (bus2.err !== 1'b0 || bus2.wea !== 1'b0) begin
      tests_failed++;
      $display("FAIL oor_err_pulse: got err=%b wea=%b, need err=0 wea=0", bus2.err, bus2.wea);
    end
    for (int i = 0; i < 12; i++) begin
      addrb2 = 4'(i);
      #1;
      tests_run++;
      if (dob2 !== 8'hA5) begin
        tests_failed++;
        $display("FAIL oor_readback[%0d]: got %h, need a5", i, dob2);
      end
    end
  endtask

  task automatic test_clear_req;
    @(negedge clk);
    bus1.clear_req = 1'b1;
    bus1.s_valid   = 1'b1;
    bus1.s_addr    = 4'd7;
    bus1.s_data    = 8'h5A;
    @(negedge clk);
    bus1.clear_req = 1'b0;
    bus1.s_valid   = 1'b0;
    tests_run++;
    if (bus1.wea !== 1'b1 || bus1.addra !== 4'd7 || bus1.dia !== 8'h5A ||
        bus1.s_ready !== 1'b0 || bus1.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL clr_host_write: got wea=%b addra=%0d dia=%h s_ready=%b busy=%b, need 1 7 5a 0 1",
               bus1.wea, bus1.addra, bus1.dia, bus1.s_ready, bus1.busy);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check_sweep1("clr_sweep", i);
      if (i == 0) begin
        addrb1 = 4'd7; #1;
        tests_run++;
        if (dob1 !== 8'h5A) begin
          tests_failed++;
          $display("FAIL clr_readback7_pre: got %h, need 5a", dob1);
        end
      end
    end
    @(negedge clk);
    check_after_sweep1("clr_sweep");
    addrb1 = 4'd7; #1;
    tests_run++;
    if (dob1 !== 8'hA5) begin
      tests_failed++;
      $display("FAIL clr_readback7: got %h, need a5", dob1);
    end
    addrb1 = 4'd3; #1;
    tests_run++;
    if (dob1 !== 8'hA5) begin
      tests_failed++;
      $display("FAIL clr_readback3: got %h, need a5", dob1);
    end
  endtask

  task automatic test_clear_mid_sweep;
    @(negedge clk);
    bus1.clear_req = 1'b1;
    @(negedge clk);
    bus1.clear_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check_sweep1("mid_clr", i);
      bus1.clear_req = (i == 8);
    end
    @(negedge clk);
    check_after_sweep1("mid_clr");
  endtask

  task automatic test_reset_mid_sweep;
    @(negedge clk);
    bus1.clear_req = 1'b1;
    @(negedge clk);
    bus1.clear_req = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      check_sweep1("rst_pre", i);
    end
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (bus1.wea !== 1'b0 || bus1.addra !== 4'd0 || bus1.busy !== 1'b1 || bus1.s_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_async: got wea=%b addra=%0d busy=%b s_ready=%b, need 0 0 1 0",
               bus1.wea, bus1.addra, bus1.busy, bus1.s_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check_sweep1("rst_restart", i);
    end
    @(negedge clk);
    check_after_sweep1("rst_restart");
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    reset_n        = 1'b0;
    addrb1         = '0;
    addrb2         = '0;
    bus1.clear_req = 1'b0;
    bus1.s_valid   = 1'b0;
    bus1.s_addr    = '0;
    bus1.s_data    = '0;
    bus2.clear_req = 1'b0;
    bus2.s_valid   = 1'b0;
    bus2.s_addr    = '0;
    bus2.s_data    = '0;

    test_reset();
    test_back_to_back();
    test_out_of_range();
    test_clear_req();
    test_clear_mid_sweep();
    test_reset_mid_sweep();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_mem_write_sequencer

// File: doc/mem_write_sequencer.md
# mem_write_sequencer

Write-port driver for a single-clock simple dual-port RAM in the FM synth's register/operator state storage. After reset, and on request, it sweeps every address and writes a clear value. Otherwise it forwards host register writes through a valid/ready handshake. Its registered outputs connect directly to the RAM's write-enable, write-address and write-data pins.

## Interface
- DATA_WIDTH, 8, RAM word width
- DEPTH, 16, number of RAM words; need not be a power of two; minimum 2
- CLEAR_VALUE, 0, DATA_WIDTH-bit word written by every clear sweep
- AW (local), $clog2(DEPTH), address width
- clk  in  1  sole clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- clear_req  in  1  one-cycle request to start a clear sweep
- s_valid  in  1  host write request valid
- s_ready  out  1  host write accepted when s_valid && s_ready
- s_addr  in  AW  host write address
- s_data  in  DATA_WIDTH  host write data
- busy  out  1  high while a clear sweep is in progress
- done  out  1  one-cycle pulse coincident with the final clear write
- err  out  1  one-cycle pulse when an accepted host write has s_addr >= DEPTH
- wea  out  1  RAM write enable (registered)
- addra  out  AW  RAM write address (registered)
- dia  out  DATA_WIDTH  RAM write data (registered)

## Operation
- FSM has two states: CLEAR and IDLE. Reset enters CLEAR with the sweep counter at 0.
- Reset values: wea=0, addra=0, dia=0, done=0, err=0, busy=1, s_ready=0.
- CLEAR behaviour, on each edge:
  - register wea=1, addra=cnt, dia=CLEAR_VALUE;
  - increment cnt;
  - on the edge that issues cnt==DEPTH-1, also set done=1, reset cnt to 0 and go to IDLE.
- busy = (state==CLEAR) || done. busy drops in the cycle after done.
- s_ready = (state==IDLE), decoded combinationally from the state register only. It never depends on s_valid.
- IDLE, accepted write with s_addr < DEPTH: register wea=1, addra=s_addr, dia=s_data.
- IDLE, accepted write with s_addr >= DEPTH: wea=0, err=1; the write is dropped.
- IDLE with no accepted write: wea=0. addra and dia hold their previous values.
- clear_req in IDLE moves the FSM to CLEAR on the next edge.
  - If a host write is accepted in that same cycle, it is still issued.
  - The sweep begins one cycle later and overwrites it.
- clear_req while already in CLEAR is ignored. The sweep is not restarted.
- Reset asserted mid-sweep or mid-write: outputs go to reset values immediately. A full sweep from address 0 restarts after release.

## Timing
- Host write latency: a handshake at edge N puts the write on wea/addra/dia during cycle N+1. The RAM commits it at edge N+1.
- Throughput: one host write per cycle, back-to-back, with no bubbles.
- Clear sweep duration: DEPTH cycles.
  - Taking edge 1 as the first edge after reset release, writes to addresses 0..DEPTH-1 are visible after edges 1..DEPTH.
  - done is high with addra=DEPTH-1.
  - s_ready rises in that same cycle.
- clear_req latency: asserted in cycle M in IDLE, s_ready falls in cycle M+1. The address-0 clear write is visible in cycle M+2.
- No combinational path from any input to wea/addra/dia/done/err.

## Structure
- The shared package holds:
  - the state enum typedef (CLEAR, IDLE);
  - a helper function computing AW from DEPTH, so the sequencer and the RAM agree on address width.
- One flat module; no sub-module is needed.
- The bench instantiates the simple dual-port RAM with zero output delay and reads it back through port B to check contents.

## Test plan
All scenarios use DATA_WIDTH=8, DEPTH=16, CLEAR_VALUE=8'hA5.
- Reset release:
  - wea high for exactly 16 cycles, addra 0..15, dia=8'hA5;
  - done pulses once with addra=15;
  - s_ready rises in the done cycle;
  - readback of all 16 words = 8'hA5.
- Back-to-back writes:
  - stimulus (addr 3, 8'h11), (4, 8'h22), (3, 8'h33) on consecutive cycles with s_valid held;
  - wea high 3 consecutive cycles, one cycle after each handshake;
  - readback gives addr3=8'h33, addr4=8'h22.
- Out-of-range address: with DEPTH=12, a write to addr 13 gives err=1 for one cycle, wea=0, and all contents unchanged.
- clear_req:
  - stimulus: clear_req together with a write (addr 7, 8'h5A) in IDLE;
  - the write is visible on the next cycle;
  - the sweep follows;
  - final addr7=8'hA5;
  - s_ready is low for the full sweep.
- clear_req mid-sweep at address 8: ignored; the sweep ends at address 15 with a single done pulse.
- reset_n pulsed low at sweep address 10:
  - wea drops asynchronously;
  - after release the sweep restarts at address 0 and runs the full 16 cycles.
